// File: rtl/store_aligner_if.sv
// Store request / memory beat bundle for store_aligner.
// slave is the aligner's view; master is the execute/memory side.
interface store_aligner_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        fault;

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, fault
  );

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, fault
  );
endinterface

// File: rtl/store_aligner.sv
// Store-path byte-lane aligner: masks store data to size, places it in little-endian
// lanes and issues word-aligned beats. STORE_ALIGNER_MISALIGNED_EN enables two-beat split stores.
module store_aligner (
  input  logic           clk,
  input  logic           rst,
  store_aligner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FAULT} state_t;

  state_t      r_state;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic        r_done;
  logic        r_fault;

  logic        w_req_ready;
  logic        w_accept;
  logic [1:0]  w_off;
  logic [31:0] w_base;
  logic [31:0] w_masked;
  logic [3:0]  w_nmask;
  logic [31:0] w_lo;
  logic [3:0]  w_strb_lo;
  logic        w_misalign;
  logic        w_fault;

  function automatic logic [31:0] f_mask_data(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'd0:    return {24'b0, d[7:0]};
      2'd1:    return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] f_lane_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign w_req_ready = (r_state == IDLE) && !rst;
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_off       = bus.req_addr[1:0];
  assign w_base      = {bus.req_addr[31:2], 2'b00};
  assign w_masked    = f_mask_data(bus.req_data, bus.req_size);
  assign w_nmask     = f_lane_mask(bus.req_size);

`ifdef STORE_ALIGNER_MISALIGNED_EN
  logic [63:0] w_lanes;
  logic [7:0]  w_strb8;
  logic        w_span;
  logic [31:0] r_hi_wdata;
  logic [3:0]  r_hi_wstrb;
  logic        r_span;

  assign w_lanes    = {32'b0, w_masked} << {w_off, 3'b000};
  assign w_strb8    = {4'b0, w_nmask} << w_off;
  assign w_lo       = w_lanes[31:0];
  assign w_strb_lo  = w_strb8[3:0];
  assign w_span     = |w_strb8[7:4];
  assign w_misalign = 1'b0;

  // Upper half of the placement is only consumed in BEAT1; loaded on every accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hi_wdata <= w_lanes[63:32];
      r_hi_wstrb <= w_strb8[7:4];
      r_span     <= w_span;
    end
  end
`else
  assign w_lo       = w_masked << {w_off, 3'b000};
  assign w_strb_lo  = w_nmask << w_off;
  assign w_misalign = ((bus.req_size == 2'd1) && w_off[0]) ||
                      ((bus.req_size == 2'd2) && (w_off != 2'd0));
`endif

  assign w_fault = (bus.req_size == 2'd3) || w_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'b0;
      r_mem_wdata <= 32'b0;
      r_mem_wstrb <= 4'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_fault) begin
              r_state <= FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state     <= BEAT0;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= w_base;
              r_mem_wdata <= w_lo;
              r_mem_wstrb <= w_strb_lo;
            end
          end
        end
        BEAT0: begin
          if (r_mem_ready_gate()) begin
`ifdef STORE_ALIGNER_MISALIGNED_EN
            if (r_span) begin
              r_state     <= BEAT1;
              r_mem_addr  <= r_mem_addr + 32'd4;
              r_mem_wdata <= r_hi_wdata;
              r_mem_wstrb <= r_hi_wstrb;
            end else
`endif
            begin
              r_state     <= IDLE;
              r_mem_valid <= 1'b0;
              r_done      <= 1'b1;
            end
          end
        end
`ifdef STORE_ALIGNER_MISALIGNED_EN
        BEAT1: begin
          if (r_mem_ready_gate()) begin
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
`endif
        FAULT:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // A beat is taken only while it is actually being presented.
  function automatic logic r_mem_ready_gate();
    return bus.mem_ready && r_mem_valid;
  endfunction

  assign bus.req_ready = w_req_ready;
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.done      = r_done;
  assign bus.fault     = r_fault;
endmodule
